// File: rtl/node_types.sv
// Search node carried through the open list; f is the priority key (lower pops first).
package node_types;
  typedef struct packed {
    logic [15:0] f;
    logic [15:0] id;
  } node_t;
endpackage

// File: rtl/pq_access_arbiter_pkg.sv
// Shared types for the open-list access arbiter.
package pq_access_arbiter_pkg;
  typedef enum logic {
    IDLE     = 1'b0,
    POP_WAIT = 1'b1
  } pq_arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping. Combinational, no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/pq_access_arbiter.sv
// Shares one priority queue between N_PUSH push ports and one pop port; one command per cycle.
// Grants are combinational; popped node appears 1 cycle after pop_ready. Full blocks pushes, empty blocks pops.
module pq_access_arbiter
  import node_types::*;
  import pq_access_arbiter_pkg::*;
#(
  parameter int N_PUSH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PUSH-1:0]       push_valid,
  input  node_t [N_PUSH-1:0]      push_node,
  output logic [N_PUSH-1:0]       push_ready,
  input  logic                    pop_req,
  output logic                    pop_ready,
  output logic                    pop_valid,
  output node_t                   pop_node,
  output logic                    pq_insert_enable,
  output logic                    pq_pop_enable,
  output node_t                   pq_node_in,
  input  logic                    pq_empty,
  input  logic                    pq_full,
  input  node_t                   pq_node_out,
  output logic [CNT_W-1:0]        push_count,
  output logic [CNT_W-1:0]        pop_count
);
  localparam int PW = (N_PUSH > 1) ? $clog2(N_PUSH) : 1;

  pq_arb_state_e     state;
  logic [PW-1:0]     rr_ptr;
  logic              last_was_pop;
  logic [N_PUSH-1:0] rr_gnt;
  logic [PW-1:0]     rr_idx;
  logic              rr_any;
  logic              pop_elig;
  logic              push_elig;
  logic              grant_push;
  logic              grant_pop;
  logic [N_PUSH-1:0] prev_push_pend;
  logic              prev_pop_pend;

  rr_arbiter #(.N(N_PUSH), .IW(PW)) u_rr (
    .req (push_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Under contention the side that lost last time wins, so neither starves.
  always_comb begin
    pop_elig   = pop_req && !pq_empty && (state == IDLE) && !rst;
    push_elig  = rr_any && !pq_full && !rst;
    grant_push = push_elig && (!pop_elig || last_was_pop);
    grant_pop  = pop_elig && !grant_push;
  end

  assign push_ready       = grant_push ? rr_gnt : '0;
  assign pq_insert_enable = grant_push;
  assign pq_pop_enable    = grant_pop;
  assign pop_ready        = grant_pop;
  assign pq_node_in       = grant_push ? push_node[rr_idx] : '0;
  assign pop_valid        = (state == POP_WAIT) && !rst;
  assign pop_node         = pop_valid ? pq_node_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      last_was_pop   <= 1'b0;
      push_count     <= '0;
      pop_count      <= '0;
      prev_push_pend <= '0;
      prev_pop_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE:     if (grant_pop) state <= POP_WAIT;
        POP_WAIT: state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (grant_push) begin
        last_was_pop <= 1'b0;
        rr_ptr       <= (rr_idx == PW'(N_PUSH - 1)) ? '0 : rr_idx + PW'(1);
        if (push_count != '1) push_count <= push_count + CNT_W'(1);
      end else if (grant_pop) begin
        last_was_pop <= 1'b1;
        if (pop_count != '1) pop_count <= pop_count + CNT_W'(1);
      end

      prev_push_pend <= push_valid & ~push_ready;
      prev_pop_pend  <= pop_req & ~pop_ready;

      assert (!(pq_insert_enable && pq_pop_enable));
      assert ($onehot0(push_ready));
      assert ((prev_push_pend & ~push_valid) == '0);
      assert (!(prev_pop_pend && !pop_req));
    end
  end
endmodule

// File: tb/tb_pq_access_arbiter.sv
// Directed bench for pq_access_arbiter with a small behavioural open-list model (capacity 4).
module tb_pq_access_arbiter;
  import node_types::*;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int QS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     push_valid;
  node_t [N-1:0]    push_node;
  logic [N-1:0]     push_ready;
  logic             pop_req, pop_ready, pop_valid;
  node_t            pop_node;
  logic             pq_insert_enable, pq_pop_enable;
  node_t            pq_node_in;
  logic             pq_empty, pq_full;
  node_t            pq_node_out;
  logic [CW-1:0]    push_count, pop_count;

  logic  use_model, drv_empty, drv_full;
  node_t drv_node_out;
  int    checks = 0;
  int    errors = 0;

  pq_access_arbiter #(.N_PUSH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_node(push_node), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_node(pop_node),
    .pq_insert_enable(pq_insert_enable), .pq_pop_enable(pq_pop_enable), .pq_node_in(pq_node_in),
    .pq_empty(pq_empty), .pq_full(pq_full), .pq_node_out(pq_node_out),
    .push_count(push_count), .pop_count(pop_count)
  );

  // Open-list model: unsorted store, pop extracts the minimum f into a registered output.
  node_t mem [8];
  int    mcnt;
  node_t mout;

  function automatic int min_idx();
    int m = 0;
    for (int j = 1; j < mcnt; j++) if (mem[j].f < mem[m].f) m = j;
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      mout <= '0;
    end else if (pq_insert_enable && mcnt < 8) begin
      mem[mcnt] <= pq_node_in;
      mcnt      <= mcnt + 1;
    end else if (pq_pop_enable && mcnt > 0) begin
      mout           <= mem[min_idx()];
      mem[min_idx()] <= mem[mcnt-1];
      mcnt           <= mcnt - 1;
    end
  end

  assign pq_empty    = use_model ? (mcnt == 0)  : drv_empty;
  assign pq_full     = use_model ? (mcnt >= QS) : drv_full;
  assign pq_node_out = use_model ? mout         : drv_node_out;

  typedef struct {
    logic [3:0]  pv;
    logic        pr;
    logic        em;
    logic        fu;
    logic [3:0]  e_prdy;
    logic        e_poprdy;
    logic        e_ins;
    logic        e_pop;
    logic [15:0] e_f;
  } vec_t;

  localparam int NV = 12;
  vec_t        tbl [NV];
  logic [15:0] fv  [4];
  logic [15:0] fs  [4];

  function automatic node_t mk(input logic [15:0] f, input logic [15:0] id);
    node_t n;
    n.f  = f;
    n.id = id;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic model);
    rst        = 1'b1;
    push_valid = '0;
    pop_req    = 1'b0;
    use_model  = model;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    fv = '{16'd9, 16'd3, 16'd7, 16'd1};
    fs = '{16'd1, 16'd3, 16'd7, 16'd9};
    //            pv       pr    em    fu    prdy     poprdy ins   pop   f
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 16'd10};
    tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 16'd12};
    tbl[2]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 16'd11};
    tbl[3]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 16'd13};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{4'b0110, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[9]  = '{4'b1100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 16'd12};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[11] = '{4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 16'd0};

    // Reset held with every input active: all outputs must be quiet.
    rst          = 1'b1;
    push_valid   = '1;
    pop_req      = 1'b1;
    use_model    = 1'b0;
    drv_empty    = 1'b0;
    drv_full     = 1'b0;
    drv_node_out = mk(16'h77, 16'h0);
    for (int i = 0; i < N; i++) push_node[i] = mk(16'(10 + i), 16'(i));
    repeat (2) @(posedge clk);
    samp();
    chk("rst_push_ready", 32'(push_ready), 0);
    chk("rst_pop_ready", 32'(pop_ready), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_pop_node", 32'(pop_node), 0);
    chk("rst_ins_en", 32'(pq_insert_enable), 0);
    chk("rst_pop_en", 32'(pq_pop_enable), 0);
    chk("rst_node_in", 32'(pq_node_in), 0);
    chk("rst_push_count", 32'(push_count), 0);
    chk("rst_pop_count", 32'(pop_count), 0);
    tick();
    rst     = 1'b0;
    pop_req = 1'b0;
    samp();
    chk("first_grant_port", 32'(push_ready), 32'h1);
    chk("first_grant_f", 32'(pq_node_in.f), 32'd10);

    // Table rows: fresh state each row, grant cycle then the following cycle.
    for (int r = 0; r < NV; r++) begin
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      push_valid = tbl[r].pv;
      pop_req    = tbl[r].pr;
      drv_empty  = tbl[r].em;
      drv_full   = tbl[r].fu;
      samp();
      chk($sformatf("row%0d_push_ready", r), 32'(push_ready), 32'(tbl[r].e_prdy));
      chk($sformatf("row%0d_pop_ready", r), 32'(pop_ready), 32'(tbl[r].e_poprdy));
      chk($sformatf("row%0d_ins_en", r), 32'(pq_insert_enable), 32'(tbl[r].e_ins));
      chk($sformatf("row%0d_pop_en", r), 32'(pq_pop_enable), 32'(tbl[r].e_pop));
      chk($sformatf("row%0d_node_in_f", r), 32'(pq_node_in.f), 32'(tbl[r].e_f));
      tick();
      samp();
      chk($sformatf("row%0d_pop_valid", r), 32'(pop_valid), 32'(tbl[r].e_pop));
      chk($sformatf("row%0d_pop_node_f", r), 32'(pop_node.f), tbl[r].e_pop ? 32'h77 : 32'h0);
      chk($sformatf("row%0d_push_count", r), 32'(push_count), 32'(tbl[r].e_ins));
      chk($sformatf("row%0d_pop_count", r), 32'(pop_count), 32'(tbl[r].e_pop));
    end

    // Push f=5, then pop it back one cycle after pop_ready.
    do_reset(1'b1);
    push_node[0] = mk(16'd5, 16'd100);
    push_valid   = 4'b0001;
    samp();
    chk("a_ins_en", 32'(pq_insert_enable), 1);
    chk("a_node_in_f", 32'(pq_node_in.f), 5);
    tick();
    push_valid = '0;
    pop_req    = 1'b1;
    samp();
    chk("a_pop_ready", 32'(pop_ready), 1);
    chk("a_pop_en", 32'(pq_pop_enable), 1);
    chk("a_pop_valid_early", 32'(pop_valid), 0);
    tick();
    pop_req = 1'b0;
    samp();
    chk("a_pop_valid", 32'(pop_valid), 1);
    chk("a_pop_node_f", 32'(pop_node.f), 5);
    chk("a_pop_node_id", 32'(pop_node.id), 100);
    chk("a_push_count", 32'(push_count), 1);
    chk("a_pop_count", 32'(pop_count), 1);

    // Four ports at once: round-robin order, then pops come back sorted by f.
    do_reset(1'b1);
    for (int i = 0; i < N; i++) push_node[i] = mk(fv[i], 16'(i));
    push_valid = '1;
    for (int c = 0; c < N; c++) begin
      samp();
      chk($sformatf("b_grant%0d", c), 32'(push_ready), 32'(1) << c);
      chk($sformatf("b_node_in%0d", c), 32'(pq_node_in.f), 32'(fv[c]));
      tick();
      push_valid[c] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      pop_req = 1'b1;
      samp();
      chk($sformatf("b_pop_ready%0d", i), 32'(pop_ready), 1);
      tick();
      pop_req = 1'b0;
      samp();
      chk($sformatf("b_pop_valid%0d", i), 32'(pop_valid), 1);
      chk($sformatf("b_pop_f%0d", i), 32'(pop_node.f), 32'(fs[i]));
      tick();
    end
    pop_req = 1'b1;
    samp();
    chk("b_empty_pop_ready", 32'(pop_ready), 0);

    // Push and pop both held: strict alternation, enables never together.
    do_reset(1'b1);
    push_node[2] = mk(16'd20, 16'd2);
    push_valid   = 4'b0100;
    pop_req      = 1'b1;
    for (int c = 0; c < 20; c++) begin
      samp();
      chk($sformatf("c_ins%0d", c), 32'(pq_insert_enable), 32'(c % 2 == 0));
      chk($sformatf("c_pop%0d", c), 32'(pq_pop_enable), 32'(c % 2 == 1));
      chk($sformatf("c_excl%0d", c), 32'(pq_insert_enable & pq_pop_enable), 0);
      tick();
    end
    samp();
    chk("c_push_count", 32'(push_count), 10);
    chk("c_pop_count", 32'(pop_count), 10);

    // Fill to capacity: pushes stall while full, pops still served.
    do_reset(1'b1);
    for (int i = 0; i < N; i++) push_node[i] = mk(fv[i], 16'(i));
    push_valid = '1;
    for (int c = 0; c < QS; c++) begin
      samp();
      chk($sformatf("d_fill%0d", c), 32'(pq_insert_enable), 1);
      tick();
    end
    samp();
    chk("d_full_push_ready", 32'(push_ready), 0);
    chk("d_full_ins_en", 32'(pq_insert_enable), 0);
    tick();
    pop_req = 1'b1;
    samp();
    chk("d_full_pop_ready", 32'(pop_ready), 1);
    chk("d_full_pop_push_ready", 32'(push_ready), 0);
    tick();
    pop_req = 1'b0;
    samp();
    chk("d_pop_valid", 32'(pop_valid), 1);
    chk("d_pop_f", 32'(pop_node.f), 1);
    chk("d_refill_grant", 32'(push_ready), 32'h1);
    tick();
    samp();
    chk("d_full_again", 32'(push_ready), 0);
    do_reset(1'b1);
    pop_req = 1'b1;
    samp();
    chk("d_empty_pop_ready", 32'(pop_ready), 0);
    chk("d_empty_pop_en", 32'(pq_pop_enable), 0);

    // Reset landing in the POP_WAIT cycle drops the popped node.
    do_reset(1'b0);
    drv_empty = 1'b0;
    drv_full  = 1'b0;
    pop_req   = 1'b1;
    samp();
    chk("e_pop_ready", 32'(pop_ready), 1);
    tick();
    pop_req = 1'b0;
    rst     = 1'b1;
    samp();
    chk("e_pop_valid_in_rst", 32'(pop_valid), 0);
    tick();
    rst = 1'b0;
    samp();
    chk("e_pop_valid_after", 32'(pop_valid), 0);
    chk("e_push_count", 32'(push_count), 0);
    chk("e_pop_count", 32'(pop_count), 0);
    tick();
    pop_req = 1'b1;
    samp();
    chk("e_idle_pop_ready", 32'(pop_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
